// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, drain FSM states and flat-index helper for the systolic array
package systolic_pkg;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int IDXW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } drain_state_t;

  // Bit offset of PE(r,c) inside the flattened accumulator bus.
  function automatic int flat_idx(input int r, input int c);
    return (r * N + c) * DW;
  endfunction

endpackage

// File: rtl/drain_ptr.sv
// rtl/drain_ptr.sv - row-major row/col pointer with clear, advance and last-position flag
module drain_ptr #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);

  localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == MAX_IDX) && (col == MAX_IDX);

endmodule

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - snapshots the PE accumulators and streams them row-major over valid/ready
module systolic_drain #(
  parameter int N = systolic_pkg::N,
  parameter int DW = systolic_pkg::DW,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*N*DW-1:0] acc_flat,
  output logic              done_o,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic [IW-1:0]     m_row,
  output logic [IW-1:0]     m_col,
  output logic              m_last,
  output logic              busy,
  output logic              drained_o
);

  import systolic_pkg::*;

  drain_state_t state_q;
  drain_state_t state_d;

  logic [DW-1:0]   snap [N*N];
  logic [IW-1:0]   ptr_row;
  logic [IW-1:0]   ptr_col;
  logic            ptr_last;
  logic            beat;
  logic [2*IW-1:0] rd_idx;

  assign m_valid = (state_q == STREAM);
  assign done_o  = (state_q == ARM);
  assign busy    = (state_q != IDLE);
  assign beat    = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     state_d = STREAM;
      STREAM:  if (beat && ptr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      drained_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      drained_o <= beat && ptr_last;
    end
  end

  // PEs only hold their results while done_o is high, so capture everything on the ARM edge.
  always_ff @(posedge clk) begin
    if (state_q == ARM) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          snap[r*N+c] <= acc_flat[flat_idx(r, c) +: DW];
        end
      end
    end
  end

  drain_ptr #(.N(N)) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (done_o),
    .adv  (beat),
    .row  (ptr_row),
    .col  (ptr_col),
    .last (ptr_last)
  );

  assign rd_idx = {ptr_row, ptr_col};
  assign m_row  = ptr_row;
  assign m_col  = ptr_col;
  assign m_last = m_valid && ptr_last;
  // Gate the mux so the uninitialised bank never shows on m_data outside STREAM.
  assign m_data = m_valid ? snap[rd_idx] : '0;

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - scoreboard bench for systolic_drain
module tb_systolic_drain;

  localparam int N  = 4;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [1:0]    c;
    logic          l;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [N*N*DW-1:0] acc_flat = '0;
  logic              done_o;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_row;
  logic [1:0]        m_col;
  logic              m_last;
  logic              busy;
  logic              drained_o;

  int   total = 0;
  int   bad = 0;
  int   beats = 0;
  logic prev_last = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  systolic_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_flat  (acc_flat),
    .done_o    (done_o),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_col     (m_col),
    .m_last    (m_last),
    .busy      (busy),
    .drained_o (drained_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input int base, input int step);
    for (int k = 0; k < N*N; k++) acc_flat[k*DW +: DW] = DW'(base + k*step);
  endtask

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < N*N; k++) begin
      e.d = acc_flat[k*DW +: DW];
      e.r = 2'(k / N);
      e.c = 2'(k % N);
      e.l = (k == N*N-1);
      q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (drained_o) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk(tag, seen, 1'b1);
  endtask

  // Beat monitor: pops and compares each accepted word, checks holds during stalls and the drained pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_last = 1'b0;
    end else begin
      chk("drained", drained_o, prev_last);
      prev_last = 1'b0;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("extra_beat", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", m_data, e.d);
          chk("row", m_row, e.r);
          chk("col", m_col, e.c);
          chk("last", m_last, e.l);
          prev_last = e.l;
        end
        beats++;
      end else if (m_valid && q.size() > 0) begin
        chk("hold_data", m_data, q[0].d);
        chk("hold_idx", {m_row, m_col}, {q[0].r, q[0].c});
      end
    end
  end

  initial begin
    int b0;
    int bp_ok;

    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_outs", {m_valid, done_o, busy, drained_o, m_last, m_row, m_col, m_data}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {m_valid, done_o, busy}, 3'b000);
      @(posedge clk);
      #1;
    end

    // Full-rate drain
    set_acc(-800, 100);
    push_exp();
    m_ready = 1'b1;
    b0 = beats;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("fr_arm", {done_o, busy, m_valid}, 3'b110);
    tick();
    for (int k = 0; k < N*N; k++) begin
      @(negedge clk);
      chk("fr_stream", {done_o, busy, m_valid}, 3'b011);
      tick();
    end
    @(negedge clk);
    chk("fr_end", {drained_o, busy, m_valid}, 3'b100);
    chk("fr_beats", beats - b0, 16);
    tick();

    // Backpressure 1,0,0 pattern
    set_acc(-300, 37);
    push_exp();
    b0 = beats;
    start = 1'b1;
    tick();
    start = 1'b0;
    bp_ok = 0;
    for (int c = 0; c < 100 && bp_ok == 0; c++) begin
      m_ready = (c % 3 == 0);
      @(negedge clk);
      if (drained_o) bp_ok = 1;
      @(posedge clk);
      #1;
    end
    chk("bp_drained", bp_ok, 1);
    chk("bp_beats", beats - b0, 16);
    m_ready = 1'b1;
    tick();

    // Snapshot isolation
    set_acc(3, 50);
    push_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    set_acc(32'h7fff, 0);
    wait_drain("iso_drained");
    chk("iso_empty", q.size(), 0);

    // Ignored start during stream and on final beat, accepted on drained cycle
    set_acc(1000, -77);
    push_exp();
    b0 = beats;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1;
    tick();
    set_acc(-5, 11);
    push_exp();
    @(negedge clk);
    chk("ign_drained", drained_o, 1'b1);
    chk("ign_beats", beats - b0, 16);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("rearm", {done_o, busy}, 2'b11);
    @(posedge clk);
    #1;
    wait_drain("rearm_drained");

    // Reset mid-stream after beat 7
    set_acc(-1234, 91);
    push_exp();
    b0 = beats;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("mid_beats", beats - b0, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst", {m_valid, busy, done_o, drained_o}, 4'b0000);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_nodrain", drained_o, 1'b0);
    @(posedge clk);
    #1;
    set_acc(42, -13);
    push_exp();
    b0 = beats;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain("post_rst_drained");
    chk("post_rst_beats", beats - b0, 16);
    chk("final_empty", q.size(), 0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Result-drain engine for the 4x4 systolic array. When compute finishes, it asserts `done_o` toward the PE grid for one cycle and snapshots the saturated 16-bit accumulator outputs of all PEs. It then streams the 16 results row-major over a valid/ready interface to the writeback path. It sits between the PE grid's `acc_o` outputs and the result writer/DMA.

## Interface
- `N`, 4, array dimension (rows = cols).
- `DW`, 16, result word width; equals PE `acc_o` width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse. Array compute is complete; sampled only in IDLE.
- `acc_flat` in N\*N\*DW: PE results. PE(r,c) is at bits `[(r*N+c)*DW +: DW]`, signed. Valid only while `done_o`=1.
- `done_o` out 1: drives PE `done` inputs. High only in ARM.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out DW: signed result word.
- `m_row` out 2 (clog2 N): row index of `m_data`.
- `m_col` out 2 (clog2 N): column index of `m_data`.
- `m_last` out 1: high with the final word, PE(N-1,N-1).
- `busy` out 1: high in ARM or STREAM.
- `drained_o` out 1: one-cycle pulse after the last word is accepted.

## Operation
- FSM states:
  - IDLE: `start` moves to ARM; otherwise stays in IDLE.
  - ARM: unconditionally moves to STREAM after exactly one cycle.
  - STREAM: on a beat (`m_valid && m_ready`) with `m_last`, moves to IDLE; otherwise stays in STREAM.
- ARM:
  - `done_o`=1.
  - At the end of this cycle, all N\*N words of `acc_flat` are registered into an internal snapshot bank.
  - Row/col pointer resets to (0,0).
- STREAM:
  - `m_valid`=1.
  - `m_data` = snapshot[row][col].
  - Each beat advances the pointer: col+1; at col=N-1, col wraps to 0 and row increments.
  - `m_last` = (row==N-1 && col==N-1).
- Snapshot data is passed through unmodified. Saturation is done in the PE; this block performs no arithmetic on the data.
- While `m_valid`=1 and `m_ready`=0, `m_data`, `m_row`, `m_col` and `m_last` hold stable.
- `m_valid` never drops before its beat completes.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` in the same cycle as the final beat is ignored, because the FSM is still in STREAM.
- `start` in the cycle `drained_o` pulses (IDLE) is accepted.
- `acc_flat` changes after ARM do not affect words being streamed.
- Reset values:
  - All outputs are 0, and the FSM is in IDLE.
  - Pointer is (0,0). Snapshot bank contents are don't-care.
- Reset mid-operation:
  - Next cycle, the FSM is in IDLE and `m_valid`, `done_o`, `busy` are 0.
  - No `drained_o` pulse.
  - The partial stream is abandoned.

## Timing
- `start` at cycle T gives `done_o`=1 and `busy`=1 in T+1.
- First word, PE(0,0), is presented with `m_valid`=1 in T+2.
- With `m_ready` held high:
  - Words 0..15 appear in T+2..T+17.
  - `m_last` is high in T+17.
  - `drained_o` is high and `busy` is 0 in T+18.
- Each `m_ready`=0 cycle during STREAM adds exactly one cycle of latency.
- Throughput: one word per cycle. There are no bubbles between beats.
- `done_o` is registered (state-decoded from the state register, no combinational path from `start`).
- `acc_flat` is sampled only on the ARM cycle edge.
- Outputs `m_*` are driven from registers and the snapshot mux. `m_ready` has no combinational path to `m_valid`.

## Structure
- Shared package `systolic_pkg` holds:
  - constants `N`=4, `DW`=16, `IDXW`=clog2(N);
  - drain state enum {IDLE, ARM, STREAM};
  - the flat-index helper function `(r*N+c)*DW`.
- One sub-module is natural: `drain_ptr`.
  - Row/col counter with clear, advance enable, column wrap into row increment, and a `last` flag.
  - The parent holds the FSM, snapshot bank and output mux.

## Test plan
- Reset, then idle:
  - Apply `rst` for 2 cycles -> all outputs 0 and FSM in IDLE.
  - Hold `start`=0 for 10 cycles -> `m_valid`, `done_o`, `busy` stay 0.
- Full-rate drain:
  - Stimulus: `acc_flat` word k = k\*100-800 (k=0..15), `m_ready`=1, `start` at T.
  - Required response:
    - `done_o` high only in T+1.
    - Words -800,-700,...,700 appear in T+2..T+17 with (row,col) = (k/4, k%4).
    - `m_last` only at k=15.
    - `drained_o` in T+18.
- Backpressure:
  - Stimulus: `m_ready` toggles 1,0,0,1,... during the stream.
  - Required response:
    - Data and indices are held during stalls; no word is lost or duplicated.
    - Total beats = 16; `drained_o` follows the last beat by one cycle.
- Snapshot isolation:
  - Stimulus: change `acc_flat` to all 0x7FFF in T+2.
  - Required response: streamed words still equal the values present in T+1.
- Ignored start:
  - Stimulus: pulse `start` at beat 5 and again in the final-beat cycle.
  - Required response: no restart, and exactly 16 beats.
  - Then pulse `start` in the `drained_o` cycle -> a new ARM follows in the next cycle.
- Reset mid-stream:
  - Stimulus: assert `rst` after beat 7.
  - Required response: next cycle `m_valid`=0, `busy`=0, no `drained_o`.
  - A subsequent `start` gives a full 16-word stream beginning at (0,0).
